reduce_task_arbiter: RTL and testbench

//  Shares one ap_ctrl_hs reduce engine (the accelerate/reduce kernel) among NUM_REQ requesters.

---
 rtl/reduce_task_arbiter.sv | 156 +++++++++++++++
 tb/tb_reduce_task_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_task_arbiter.sv
// Round-robin arbiter sharing one ap_ctrl_hs reduce engine among NUM_REQ requesters.
// Drives the start handshake, returns tagged results and guards against a hung engine.
module reduce_task_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ARG_W       = 32,
    parameter int RES_W       = 32,
    parameter int TIMEOUT_CYC = 4096,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*ARG_W-1:0] req_arg,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     eng_ap_start,
    output logic [ARG_W-1:0]         eng_arg,
    input  logic                     eng_ap_ready,
    input  logic                     eng_ap_done,
    input  logic [RES_W-1:0]         eng_ap_return,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [RES_W-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     err_timeout,
    output logic [31:0]              task_cnt
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        RESP  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [WD_W-1:0]   wd;
    logic              err_q;
    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W:0]     cand;
    logic              capture;
    logic              expire;
    logic              wd_last;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        if (id == ID_W'(NUM_REQ - 1))
            return '0;
        return id + ID_W'(1);
    endfunction

    // Scan from ptr upward; iterating high-to-low offsets lets the lowest offset win.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int s = NUM_REQ - 1; s >= 0; s--) begin
            cand = {1'b0, ptr} + (ID_W+1)'(s);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (req[cand[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand[ID_W-1:0];
            end
        end
    end

    assign wd_last = (TIMEOUT_CYC != 0) && (wd == WD_LAST);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld)
                    state_nxt = START;
            end
            START: begin
                if (eng_ap_ready && eng_ap_done) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (wd_last) begin
                    expire    = 1'b1;
                    state_nxt = RESP;
                end else if (eng_ap_ready) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (eng_ap_done) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (wd_last) begin
                    expire    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_nxt = err_q ? HALT : IDLE;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            wd          <= '0;
            gnt         <= '0;
            eng_arg     <= '0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            err_q       <= 1'b0;
            err_timeout <= 1'b0;
            task_cnt    <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= '0;
            if (state == START || state == RUN)
                wd <= wd + WD_W'(1);
            if (state == IDLE && pick_vld) begin
                gnt     <= NUM_REQ'(1) << pick_id;
                eng_arg <= req_arg[int'(pick_id)*ARG_W +: ARG_W];
                rsp_id  <= pick_id;
                ptr     <= next_ptr(pick_id);
                wd      <= '0;
            end
            if (capture) begin
                rsp_data <= eng_ap_return;
                err_q    <= 1'b0;
            end
            // A hung engine still yields a response so the requester is not left waiting.
            if (expire) begin
                rsp_data    <= '0;
                err_q       <= 1'b1;
                err_timeout <= 1'b1;
            end
            if (rsp_valid && rsp_ready)
                task_cnt <= task_cnt + 32'd1;
        end
    end

    assign eng_ap_start = (state == START);
    assign rsp_valid    = (state == RESP);
    assign rsp_err      = (state == RESP) && err_q;

endmodule

// File: tb/tb_reduce_task_arbiter.sv
// Bench for reduce_task_arbiter: engine/requester stimulus, cycle model and directed scenarios.
module tb_reduce_task_arbiter;

    localparam int NREQ  = 4;
    localparam int ARG_W = 32;
    localparam int RES_W = 32;
    localparam int TO    = 16;
    localparam int IDW   = 2;

    logic                    clk;
    logic                    reset;
    logic [NREQ-1:0]         req;
    logic [NREQ*ARG_W-1:0]   req_arg;
    logic [NREQ-1:0]         gnt;
    logic                    eng_ap_start;
    logic [ARG_W-1:0]        eng_arg;
    logic                    eng_ap_ready;
    logic                    eng_ap_done;
    logic [RES_W-1:0]        eng_ap_return;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [RES_W-1:0]        rsp_data;
    logic                    rsp_err;
    logic                    err_timeout;
    logic [31:0]             task_cnt;

    reduce_task_arbiter #(
        .NUM_REQ(NREQ), .ARG_W(ARG_W), .RES_W(RES_W), .TIMEOUT_CYC(TO)
    ) dut (
        .clock(clk), .reset(reset), .req(req), .req_arg(req_arg), .gnt(gnt),
        .eng_ap_start(eng_ap_start), .eng_arg(eng_arg), .eng_ap_ready(eng_ap_ready),
        .eng_ap_done(eng_ap_done), .eng_ap_return(eng_ap_return), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .err_timeout(err_timeout), .task_cnt(task_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_WAIT_RDY = 1, M_WAIT_DONE = 2, M_RESP = 3, M_HALT = 4;
    int              m_mode = M_IDLE;
    int              m_ptr = 0;
    int              m_age = 0;
    int              mk;
    bit              m_fail = 0;
    bit              m_init = 0;
    bit              m_rst = 0;
    bit              found;
    logic [NREQ-1:0] e_gnt;
    logic [ARG_W-1:0] e_arg;
    logic [IDW-1:0]  e_id;
    logic [RES_W-1:0] e_data;
    logic            e_err;
    logic            e_to;
    logic [31:0]     e_cnt;

    always @(posedge clk) begin
        e_gnt = '0;
        m_rst = 0;
        if (reset) begin
            m_init = 1; m_rst = 1; m_mode = M_IDLE; m_ptr = 0; m_age = 0; m_fail = 0;
            e_arg = '0; e_id = '0; e_data = '0; e_err = 0; e_to = 0; e_cnt = '0;
        end else if (m_mode == M_IDLE) begin
            found = 0;
            for (int s = 0; s < NREQ; s++) begin
                mk = (m_ptr + s) % NREQ;
                if (!found && req[mk]) begin
                    found = 1;
                    e_gnt = '0;
                    e_gnt[mk] = 1'b1;
                    e_arg = req_arg[mk*ARG_W +: ARG_W];
                    e_id = IDW'(mk);
                    m_ptr = (mk + 1) % NREQ;
                    m_age = 0;
                    m_mode = M_WAIT_RDY;
                end
            end
        end else if (m_mode == M_WAIT_RDY || m_mode == M_WAIT_DONE) begin
            m_age++;
            if (eng_ap_done && (m_mode == M_WAIT_DONE || eng_ap_ready)) begin
                e_data = eng_ap_return; e_err = 0; m_mode = M_RESP;
            end else if (m_age == TO) begin
                e_data = '0; e_err = 1; e_to = 1; m_fail = 1; m_mode = M_RESP;
            end else if (eng_ap_ready) begin
                m_mode = M_WAIT_DONE;
            end
        end else if (m_mode == M_RESP) begin
            if (rsp_ready) begin
                e_cnt = e_cnt + 1;
                m_mode = m_fail ? M_HALT : M_IDLE;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("gnt", gnt, e_gnt);
            chk("eng_ap_start", eng_ap_start, m_mode == M_WAIT_RDY);
            chk("rsp_valid", rsp_valid, m_mode == M_RESP);
            chk("rsp_err", rsp_err, (m_mode == M_RESP) && e_err);
            chk("err_timeout", err_timeout, e_to);
            chk("task_cnt", task_cnt, e_cnt);
            if (m_rst || m_mode == M_WAIT_RDY || m_mode == M_WAIT_DONE)
                chk("eng_arg", eng_arg, e_arg);
            if (m_rst || m_mode == M_RESP) begin
                chk("rsp_id", rsp_id, e_id);
                chk("rsp_data", rsp_data, e_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit   bfm_on = 1, rand_eng = 0, rand_req = 0, rand_rdy = 0, hold_all = 0;
    bit   eng_act = 0;
    int   eng_cnt = 0, eng_rl = 0, eng_dl = 1;
    logic [RES_W-1:0] eng_ret = '0;

    task automatic step();
        @(posedge clk);
        #1;
        if (bfm_on) begin
            eng_ap_ready = 0;
            eng_ap_done = 0;
            eng_ap_return = $urandom;
            if (reset) begin
                eng_act = 0;
            end else begin
                if (eng_act) begin
                    eng_cnt++;
                end else if (eng_ap_start) begin
                    eng_act = 1;
                    eng_cnt = 0;
                    if (rand_eng) begin
                        eng_rl = $urandom_range(0, 3);
                        eng_dl = ($urandom_range(0, 7) == 0) ? TO - 1 : eng_rl + $urandom_range(0, 8);
                        eng_ret = $urandom;
                    end
                end
                if (eng_act && rsp_valid) eng_act = 0;
                if (eng_act) begin
                    if (eng_cnt == eng_rl) eng_ap_ready = 1;
                    if (eng_cnt == eng_dl) begin
                        eng_ap_done = 1;
                        eng_ap_return = eng_ret;
                        eng_act = 0;
                    end
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && !hold_all) req[i] = 1'b0;
            if (rand_req && !req[i] && $urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                req_arg[i*ARG_W +: ARG_W] = $urandom;
            end
        end
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_gnt(input string nm);
        int n = 0;
        do begin step(); n++; end while (gnt == '0 && n < 100);
        if (gnt == '0) chk({nm, "_gnt_wait"}, 0, 1);
    endtask

    task automatic wait_rsp(input string nm, output int n);
        n = 0;
        do begin step(); n++; end while (!rsp_valid && n < 200);
        if (!rsp_valid) chk({nm, "_rsp_wait"}, 0, 1);
    endtask

    task automatic drain(input int cycles);
        req = '0; hold_all = 0; rsp_ready = 1;
        for (int i = 0; i < cycles; i++) step();
    endtask

    int order[5];
    int ng, lat;

    initial begin
        reset = 1; req = '0; req_arg = '0; rsp_ready = 0;
        eng_ap_ready = 0; eng_ap_done = 0; eng_ap_return = '0;
        step(); step();
        chk("rst_outputs", {gnt, eng_ap_start, rsp_valid, rsp_err, err_timeout, task_cnt}, 64'd0);
        reset = 0;
        step();

        // T1: single request from requester 2
        rsp_ready = 1; eng_rl = 1; eng_dl = 5; eng_ret = 32'hAA;
        req_arg[2*ARG_W +: ARG_W] = 32'h55; req[2] = 1;
        wait_gnt("t1");
        chk("t1_gnt", gnt, 4'b0100);
        chk("t1_arg", eng_arg, 32'h55);
        wait_rsp("t1", lat);
        chk("t1_rsp_id", rsp_id, 2);
        chk("t1_rsp_data", rsp_data, 32'hAA);
        step();
        chk("t1_task_cnt", task_cnt, 1);
        chk("t1_valid_low", rsp_valid, 0);

        // T2: all four held from a fresh pointer
        reset = 1; step(); reset = 0;
        eng_rl = 0; eng_dl = 1; rsp_ready = 1; hold_all = 1; req = 4'b1111;
        ng = 0;
        for (int c = 0; c < 200 && ng < 5; c++) begin
            step();
            if (gnt != '0) begin
                chk("t2_onehot", $onehot(gnt), 1);
                for (int b = 0; b < NREQ; b++) if (gnt[b]) order[ng] = b;
                ng++;
            end
        end
        chk("t2_count", ng, 5);
        chk("t2_order0", order[0], 0);
        chk("t2_order1", order[1], 1);
        chk("t2_order2", order[2], 2);
        chk("t2_order3", order[3], 3);
        chk("t2_order4", order[4], 0);
        drain(20);

        // T3: ready and done in the same cycle
        eng_rl = 1; eng_dl = 1; eng_ret = 32'h1234;
        req_arg[0 +: ARG_W] = 32'h3; req[0] = 1;
        wait_gnt("t3");
        step();
        step();
        chk("t3_start_low", eng_ap_start, 0);
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_data", rsp_data, 32'h1234);
        drain(10);

        // T4: response back-pressure while another requester waits
        rsp_ready = 0; eng_rl = 0; eng_dl = 2; eng_ret = 32'hBEEF;
        req[3] = 1;
        wait_rsp("t4", lat);
        req_arg[1*ARG_W +: ARG_W] = 32'h11; req[1] = 1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t4_hold", {gnt, rsp_valid, rsp_id, rsp_data},
                {4'b0000, 1'b1, 2'd3, 32'hBEEF});
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("t4_after_hs", {gnt, rsp_valid}, 5'b0);
        step();
        chk("t4_gnt1", gnt, 4'b0010);
        drain(20);

        // Random traffic
        rand_eng = 1; rand_req = 1; rand_rdy = 1;
        for (int c = 0; c < 800; c++) step();
        rand_req = 0; rand_rdy = 0; rsp_ready = 1;
        for (int c = 0; c < 150; c++) step();
        rand_eng = 0;
        drain(5);

        // T5: engine never finishes
        rsp_ready = 0; eng_rl = 0; eng_dl = 100000;
        req[2] = 1;
        wait_gnt("t5");
        wait_rsp("t5", lat);
        chk("t5_latency", lat, TO);
        chk("t5_rsp_err", rsp_err, 1);
        chk("t5_rsp_data", rsp_data, 0);
        chk("t5_err_timeout", err_timeout, 1);
        rsp_ready = 1;
        step();
        hold_all = 1; req = 4'b1111; ng = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (gnt != '0) ng++;
        end
        chk("t5_no_gnt", ng, 0);
        chk("t5_halt_out", {rsp_valid, eng_ap_start, err_timeout}, 3'b001);

        // T6: reset mid-run, stale done, then a new request
        hold_all = 0; req = '0;
        reset = 1; step(); reset = 0;
        chk("t6_rst_clear", {err_timeout, task_cnt}, 33'd0);
        eng_rl = 0; eng_dl = 20; req[0] = 1;
        wait_gnt("t6");
        for (int c = 0; c < 4; c++) step();
        reset = 1; step(); reset = 0;
        chk("t6_rst_outputs", {gnt, eng_ap_start, rsp_valid, rsp_err, err_timeout, task_cnt, eng_arg}, 64'd0);
        bfm_on = 0; eng_ap_ready = 0; eng_ap_done = 1; eng_ap_return = 32'hDEAD;
        step();
        eng_ap_done = 0;
        step();
        chk("t6_stale_done", {rsp_valid, eng_ap_start}, 2'b00);
        bfm_on = 1; eng_rl = 0; eng_dl = 3; eng_ret = 32'h77;
        req_arg[1*ARG_W +: ARG_W] = 32'h9; req[1] = 1;
        wait_rsp("t6", lat);
        chk("t6_rsp_id", rsp_id, 1);
        chk("t6_rsp_data", rsp_data, 32'h77);
        drain(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
